// File: rtl/coder_pkg.sv
// Shared types and defaults for the arithmetic-coder lane merger.
package coder_pkg;

    localparam int N_LANES_DEF = 8;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } merge_state_e;

    typedef logic [$clog2(N_LANES_DEF)-1:0] lane_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping at N.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int LW = $clog2(N);

    logic [LW:0]   sum;
    logic [LW-1:0] j;

    // Walk offsets from the far end down so the nearest requester wins last.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        sum       = '0;
        j         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (LW+1)'(k);
            j   = (sum >= (LW+1)'(N)) ? LW'(sum - (LW+1)'(N)) : LW'(sum);
            if (req[j]) begin
                gnt       = '0;
                gnt[j]    = 1'b1;
                gnt_idx   = j;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coder_lane_merger.sv
// Merges per-lane coder byte streams into one idx/byte/last stream with round-robin arbitration.
// Optional per-lane byte counters are built when LANE_BYTE_CNT_EN is defined.
module coder_lane_merger
    import coder_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IDX_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_LANES-1:0]          lane_valid,
    input  logic [N_LANES*DATA_W-1:0]   lane_byte,
    input  logic [N_LANES-1:0]          lane_last,
    output logic [N_LANES-1:0]          lane_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_idx,
    output logic [DATA_W-1:0]           out_byte,
    output logic                        out_last,
    output logic                        frame_done
`ifdef LANE_BYTE_CNT_EN
    ,
    input  logic [$clog2(N_LANES)-1:0]  stat_sel,
    input  logic                        stat_clr,
    output logic [31:0]                 stat_count
`endif
);

    localparam int LW = $clog2(N_LANES);

    logic [N_LANES-1:0][DATA_W-1:0] lane_bytes;
    logic [N_LANES-1:0]             lane_done;
    logic [N_LANES-1:0]             req;
    logic [N_LANES-1:0]             gnt_oh;
    logic [LW-1:0]                  gnt_idx;
    logic [LW-1:0]                  rr_ptr;
    logic                           gnt_valid;
    logic                           load_en;
    logic                           xfer;
    logic                           frame_last;
    logic                           frame_end;
    merge_state_e                   state, state_nxt;

    assign lane_bytes = lane_byte;
    assign load_en    = ~out_valid | out_ready;

    // DRAIN masks all requests so next-frame bytes cannot overtake the last beat.
    assign req = lane_valid & ~lane_done & {N_LANES{state != DRAIN}};

    rr_arbiter #(.N(N_LANES)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt       (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign xfer       = load_en & gnt_valid;
    assign lane_ready = (xfer & ~rst_n) ? gnt_oh : '0;
    assign frame_last = lane_last[gnt_idx] & ((lane_done | gnt_oh) == '1);
    assign frame_end  = (state == DRAIN) & out_valid & out_ready & out_last;
    assign frame_done = frame_end;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_byte  <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_idx   <= IDX_W'(gnt_idx);
            out_byte  <= lane_bytes[gnt_idx];
            out_last  <= frame_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lane_done <= '0;
            rr_ptr    <= '0;
        end else if (frame_end) begin
            lane_done <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            if (lane_last[gnt_idx])
                lane_done <= lane_done | gnt_oh;
            rr_ptr <= (gnt_idx == LW'(N_LANES - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer)              state_nxt = RUN;
            RUN:     if (xfer & frame_last) state_nxt = DRAIN;
            DRAIN:   if (frame_end)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

`ifdef LANE_BYTE_CNT_EN
    logic [N_LANES-1:0][31:0] byte_cnt;
    logic                     frame_start;

    assign frame_start = (state == IDLE) & xfer;

    // Frame start restarts every lane, still counting the opening beat.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            byte_cnt   <= '0;
            stat_count <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (stat_clr)
                    byte_cnt[i] <= '0;
                else if (frame_start)
                    byte_cnt[i] <= {31'd0, gnt_oh[i]};
                else if (xfer & gnt_oh[i])
                    byte_cnt[i] <= byte_cnt[i] + 32'd1;
            end
            stat_count <= byte_cnt[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_coder_lane_merger.sv
// Bench for coder_lane_merger: per-lane source queues, cycle model of the merge rules, directed frames.
module tb_coder_lane_merger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  lane_valid = '0;
    logic [63:0] lane_byte = '0;
    logic [7:0]  lane_last = '0;
    logic [7:0]  lane_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_idx;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        frame_done;

    coder_lane_merger dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lane_valid (lane_valid),
        .lane_byte  (lane_byte),
        .lane_last  (lane_last),
        .lane_ready (lane_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Source streams: {last, byte} per lane
    logic [8:0] src [8][64];
    int         head [8];
    int         tail [8];
    logic [7:0] lane_en = 8'hFF;
    logic       rdy = 1'b1;

    // Model of the merger's observable state
    bit         m_ov, m_last, m_drain;
    int         m_idx, m_rr;
    logic [7:0] m_byte, m_done;

    int         acc_idx [$];
    logic [7:0] acc_byte [$];
    int         fd_cnt = 0;
    int         last_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int lane, input logic [7:0] b, input bit last);
        src[lane][tail[lane]] = {last, b};
        tail[lane]++;
    endtask

    task automatic model_reset();
        m_ov = 0; m_last = 0; m_drain = 0; m_idx = 0; m_rr = 0;
        m_byte = '0; m_done = '0;
    endtask

    // One clock: called just after a falling edge, returns just after the next one.
    task automatic tick();
        int         g;
        logic [7:0] exp_rdy;
        logic [8:0] ent;
        for (int i = 0; i < 8; i++) begin
            lane_valid[i] = lane_en[i] && (head[i] != tail[i]);
            ent = lane_valid[i] ? src[i][head[i]] : 9'h0;
            lane_last[i] = ent[8];
            lane_byte[i*8 +: 8] = ent[7:0];
        end
        out_ready = rdy;
        #1;
        g = -1;
        if ((!m_ov || rdy) && !m_drain)
            for (int k = 0; k < 8; k++) begin
                int l;
                l = (m_rr + k) % 8;
                if (g < 0 && lane_valid[l] && !m_done[l]) g = l;
            end
        exp_rdy = (g >= 0) ? 8'(1 << g) : 8'h00;
        chk("lane_ready", lane_ready, exp_rdy);
        chk("frame_done", frame_done, m_drain && m_ov && rdy && m_last);
        if (out_valid && out_ready) begin
            acc_idx.push_back(int'(out_idx));
            acc_byte.push_back(out_byte);
            if (out_last) last_cnt++;
        end
        if (frame_done) fd_cnt++;
        @(posedge clk);
        if (m_ov && rdy) begin
            if (m_last) begin
                m_done = '0; m_rr = 0; m_drain = 0;
            end
            m_ov = 0;
        end
        if (g >= 0) begin
            ent    = src[g][head[g]];
            m_ov   = 1;
            m_idx  = g;
            m_byte = ent[7:0];
            m_last = ent[8] && ((m_done | 8'(1 << g)) == 8'hFF);
            if (ent[8]) m_done[g] = 1'b1;
            if (m_last) m_drain = 1;
            m_rr = (g + 1) % 8;
            head[g]++;
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_idx", out_idx, m_idx);
            chk("out_byte", out_byte, m_byte);
            chk("out_last", out_last, m_last);
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input int budget, input bit rand_rdy);
        int fd0;
        int n;
        fd0 = fd_cnt;
        n = 0;
        while (fd_cnt == fd0 && n < budget) begin
            if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        chk("frame_end_seen", fd_cnt - fd0, 1);
    endtask

    initial begin
        int fd0, lc0;
        for (int i = 0; i < 8; i++) begin head[i] = 0; tail[i] = 0; end
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_lane_ready", lane_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);

        // Only lane 3 sends; the frame must not end until every lane has finished
        rdy = 1'b1;
        push(3, 8'h11, 0); push(3, 8'h22, 0); push(3, 8'h33, 1);
        fd0 = fd_cnt; lc0 = last_cnt;
        repeat (10) tick();
        chk("t1_no_frame_done", fd_cnt, fd0);
        chk("t1_no_out_last", last_cnt, lc0);
        chk("t1_beats", acc_idx.size(), 3);
        for (int i = 0; i < 8; i++)
            if (i != 3) push(i, 8'($urandom_range(0, 255)), 1);
        run_frame(40, 0);
        chk("t1_last_cnt", last_cnt - lc0, 1);

        // All lanes streaming, with a 5-cycle output stall mid-frame
        acc_idx.delete(); acc_byte.delete();
        for (int i = 0; i < 8; i++)
            for (int b = 0; b < 3; b++) push(i, 8'($urandom_range(0, 255)), b == 2);
        begin
            int n;
            int fd1;
            fd1 = fd_cnt;
            n = 0;
            while (fd_cnt == fd1 && n < 100) begin
                rdy = !(n >= 6 && n < 11);
                tick();
                n++;
            end
            chk("t2_frame_end", fd_cnt - fd1, 1);
        end
        chk("t2_beats", acc_idx.size(), 24);
        for (int k = 0; k < acc_idx.size(); k++) chk("t2_rr_order", acc_idx[k], k % 8);

        // Lanes finish in order 5,0,7,1,2,3,4,6 with random back-pressure
        acc_idx.delete(); acc_byte.delete();
        lc0 = last_cnt;
        for (int i = 0; i < 8; i++) begin
            int len;
            len = (i == 5) ? 1 : (i == 0 || i == 7) ? 2 : 3;
            for (int b = 0; b < len; b++) push(i, 8'($urandom_range(0, 255)), b == len - 1);
        end
        run_frame(200, 1);
        chk("t4_last_cnt", last_cnt - lc0, 1);
        chk("t4_final_idx", acc_idx[acc_idx.size() - 1], 6);

        // Lane 2 keeps offering 0xAA after its last byte: held back to the next frame
        rdy = 1'b1;
        push(2, 8'($urandom_range(0, 255)), 0);
        push(2, 8'($urandom_range(0, 255)), 1);
        push(2, 8'hAA, 1);
        for (int i = 0; i < 8; i++)
            if (i != 2)
                for (int b = 0; b < 4; b++) push(i, 8'($urandom_range(0, 255)), b == 3);
        run_frame(200, 1);
        acc_idx.delete(); acc_byte.delete();
        rdy = 1'b1;
        repeat (3) tick();
        chk("t5_next_beats", acc_idx.size(), 1);
        chk("t5_first_byte", acc_byte[0], 8'hAA);
        chk("t5_first_idx", acc_idx[0], 2);

        // Reset while a beat is pending
        for (int i = 0; i < 8; i++) head[i] = tail[i];
        for (int i = 0; i < 8; i++) begin
            push(i, 8'($urandom_range(0, 255)), 0);
            push(i, 8'($urandom_range(0, 255)), 1);
        end
        rdy = 1'b0;
        repeat (2) tick();
        chk("t6_pending", out_valid, 1);
        rst_n = 1'b1;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_lane_ready", lane_ready, 0);
        chk("t6_rst_out_last", out_last, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b0;
        acc_idx.delete(); acc_byte.delete();
        rdy = 1'b1;
        run_frame(60, 0);
        chk("t6_first_idx", acc_idx[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
